// File: rtl/updi_tx_serializer.sv
// UPDI transmit serialiser: bytes in over valid/ready, UART 8E1/8E2 frames out.
// Optionally prefixes each packet with the 0x55 SYNC character.
module updi_tx_serializer #(
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 2,
    parameter bit SEND_SYNC = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    output logic        o_tx,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  STOP_M1 = 3'(STOP_BITS - 1);

    state_t      state;
    logic [7:0]  shift;
    logic        par;
    logic        last_q;
    logic        in_pkt;
    logic [15:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic        bit_end;

    assign bit_end = (div_cnt == 16'd0);
    assign o_busy  = (state != IDLE) || in_pkt;
    assign o_ready = i_resetn && (state == IDLE)
                   && (in_pkt || !SEND_SYNC);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state        <= IDLE;
            shift        <= 8'd0;
            par          <= 1'b0;
            last_q       <= 1'b0;
            in_pkt       <= 1'b0;
            div_cnt      <= 16'd0;
            bit_cnt      <= 3'd0;
            o_tx         <= 1'b1;
            o_tx_en      <= 1'b0;
            o_frame_done <= 1'b0;
            o_byte_cnt   <= 16'd0;
        end else begin
            o_frame_done <= 1'b0;
            if (state != IDLE)
                div_cnt <= bit_end ? DIV_M1 : div_cnt - 16'd1;
            unique case (state)
                IDLE: begin
                    if (i_valid && !in_pkt && SEND_SYNC) begin
                        shift      <= 8'h55;
                        par        <= 1'b0;
                        last_q     <= 1'b0;
                        in_pkt     <= 1'b1;
                        o_byte_cnt <= 16'd0;
                        div_cnt    <= DIV_M1;
                        o_tx       <= 1'b0;
                        o_tx_en    <= 1'b1;
                        state      <= START;
                    end else if (i_valid && o_ready) begin
                        shift   <= i_data;
                        par     <= ^i_data;
                        last_q  <= i_last;
                        in_pkt  <= 1'b1;
                        div_cnt <= DIV_M1;
                        o_tx    <= 1'b0;
                        o_tx_en <= 1'b1;
                        state   <= START;
                        if (!in_pkt)
                            o_byte_cnt <= 16'd1;
                        else if (o_byte_cnt != 16'hFFFF)
                            o_byte_cnt <= o_byte_cnt + 16'd1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        o_tx    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= 3'd7;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            o_tx    <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt - 3'd1;
                        end else begin
                            o_tx  <= par;
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        o_tx    <= 1'b1;
                        bit_cnt <= STOP_M1;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end else begin
                            o_tx_en <= 1'b0;
                            state   <= IDLE;
                            // packet closes only on a payload byte flagged last
                            if (last_q) begin
                                o_frame_done <= 1'b1;
                                in_pkt       <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
